// File: rtl/iter_scalar_alu.sv
// Clocked scalar ALU: add/sub/mov/cmp in one cycle, shift-add multiply and
// restoring divide one bit per cycle, valid/ready on both sides.
module iter_scalar_alu #(
    parameter int N     = 16,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   F,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Result,
    output logic [N-1:0] ResultHi,
    output logic [3:0]   Flags
);

    // state | meaning
    // IDLE  | ready for an op
    // MUL   | shift-add multiply, one multiplier bit per edge
    // DIV   | restoring divide, one dividend bit per edge
    // DONE  | result held until out_ready
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N-1:0]      res, res_nxt;
    logic [N-1:0]      hi, hi_nxt;
    logic [N-1:0]      opnd, opnd_nxt;
    logic [3:0]        flags, flags_nxt;

    logic [N:0]        add_sum;
    logic [N-1:0]      sub_diff;
    logic              v_add, v_sub;
    logic [N-1:0]      cmp_res;
    logic [N:0]        mul_sum;
    logic [N-1:0]      mul_lo, mul_hi;
    logic [N:0]        div_shift;
    logic              div_ge;
    logic [N-1:0]      div_rem, div_quo;

    assign add_sum  = {1'b0, A} + {1'b0, B};
    assign sub_diff = A - B;
    assign v_add    = (A[N-1] == B[N-1]) && (add_sum[N-1] != A[N-1]);
    assign v_sub    = (A[N-1] != B[N-1]) && (sub_diff[N-1] != A[N-1]);
    assign cmp_res  = ((A < B) && (A != '0)) ? A : B;

    // Multiply: hi:res holds partial product over the shifting multiplier.
    assign mul_sum  = {1'b0, hi} + (res[0] ? {1'b0, opnd} : '0);
    assign mul_lo   = {mul_sum[0], res[N-1:1]};
    assign mul_hi   = mul_sum[N:1];

    // Divide: hi is the partial remainder, res shifts dividend out / quotient in.
    // A successful trial leaves a value below opnd, so N-bit subtraction suffices.
    assign div_shift = {hi, res[N-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_rem   = div_ge ? (div_shift[N-1:0] - opnd) : div_shift[N-1:0];
    assign div_quo   = {res[N-2:0], div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            res   <= '0;
            hi    <= '0;
            opnd  <= '0;
            flags <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            res   <= res_nxt;
            hi    <= hi_nxt;
            opnd  <= opnd_nxt;
            flags <= flags_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        res_nxt   = res;
        hi_nxt    = hi;
        opnd_nxt  = opnd;
        flags_nxt = flags;
        case (state)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    hi_nxt    = '0;
                    state_nxt = S_DONE;
                    case (F)
                        3'b000: begin
                            res_nxt   = add_sum[N-1:0];
                            flags_nxt = {1'b0, v_add, add_sum[N], add_sum[N-1:0] == '0};
                        end
                        3'b001: begin
                            res_nxt   = sub_diff;
                            flags_nxt = {1'b0, v_sub, A >= B, sub_diff == '0};
                        end
                        3'b011: begin
                            res_nxt   = A;
                            opnd_nxt  = B;
                            flags_nxt = '0;
                            cnt_nxt   = CNT_W'(N);
                            state_nxt = S_MUL;
                        end
                        3'b100: begin
                            if (B == '0) begin
                                res_nxt   = '1;
                                hi_nxt    = A;
                                flags_nxt = 4'b1000;
                            end else begin
                                res_nxt   = A;
                                opnd_nxt  = B;
                                flags_nxt = '0;
                                cnt_nxt   = CNT_W'(N);
                                state_nxt = S_DIV;
                            end
                        end
                        3'b101: begin
                            res_nxt   = cmp_res;
                            flags_nxt = {3'b000, cmp_res == '0};
                        end
                        default: begin
                            res_nxt   = B;
                            flags_nxt = {3'b000, B == '0};
                        end
                    endcase
                end
            end
            S_MUL: begin
                res_nxt   = mul_lo;
                hi_nxt    = mul_hi;
                flags_nxt = {3'b000, mul_lo == '0};
                cnt_nxt   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            end
            S_DIV: begin
                res_nxt   = div_quo;
                hi_nxt    = div_rem;
                flags_nxt = {3'b000, div_quo == '0};
                cnt_nxt   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign Result    = res;
    assign ResultHi  = hi;
    assign Flags     = flags;

endmodule

// File: tb/tb_iter_scalar_alu.sv
// Directed plus random bench for iter_scalar_alu; expectations come from a
// behavioural model pushed to a scoreboard queue at drive time.
module tb_iter_scalar_alu;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic [2:0]    f = '0;
    logic          in_ready, out_valid;
    logic [N-1:0]  result, result_hi;
    logic [3:0]    flags;

    iter_scalar_alu #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .F(f),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(result), .ResultHi(result_hi), .Flags(flags)
    );

    always #5 clk = ~clk;

    // lat = index of the edge after accept (edge 0) where out_valid rises
    typedef struct {
        logic [N-1:0] res;
        logic [N-1:0] hi;
        logic [3:0]   flg;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic [2:0] mf);
        exp_t e;
        int ua, ub, sa, sb_i, s;
        logic [31:0] p;
        logic c, v, dz;
        ua = int'(ma); ub = int'(mb);
        sa = $signed(ma); sb_i = $signed(mb);
        c = 1'b0; v = 1'b0; dz = 1'b0;
        e.hi = '0; e.lat = 0;
        case (mf)
            3'd0: begin
                e.res = N'(ua + ub); c = (ua + ub) > 65535;
                s = sa + sb_i; v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                e.res = N'(ua - ub); c = (ua >= ub);
                s = sa - sb_i; v = (s > 32767) || (s < -32768);
            end
            3'd3: begin
                p = 32'(ma) * 32'(mb);
                e.res = p[15:0]; e.hi = p[31:16]; e.lat = N;
            end
            3'd4: begin
                if (ub == 0) begin
                    e.res = 16'hFFFF; e.hi = ma; dz = 1'b1;
                end else begin
                    e.res = N'(ua / ub); e.hi = N'(ua % ub); e.lat = N;
                end
            end
            3'd5: e.res = (ua < ub && ua != 0) ? ma : mb;
            default: e.res = mb;
        endcase
        e.flg = {dz, v, c, e.res == '0};
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [N-1:0] oa, input logic [N-1:0] ob,
                          input logic [2:0] of, input int hold,
                          output logic [N-1:0] ro, output logic [N-1:0] rh, output logic [3:0] rf);
        exp_t e;
        int lat;
        logic [N-1:0] r0;
        sb.push_back(model(oa, ob, of));
        @(negedge clk);
        check({tag, ".in_ready_idle"}, in_ready, 1'b1);
        in_valid = 1'b1; a = oa; b = ob; f = of;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = N'($urandom); b = N'($urandom); f = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check({tag, ".latency"}, lat, e.lat);
        check({tag, ".result"}, result, e.res);
        check({tag, ".result_hi"}, result_hi, e.hi);
        check({tag, ".flags"}, flags, e.flg);
        ro = result; rh = result_hi; rf = flags;
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, out_valid, 1'b1);
            check({tag, ".hold_ready"}, in_ready, 1'b0);
            check({tag, ".hold_result"}, {result_hi, result}, {e.hi, r0});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".drain_valid"}, out_valid, 1'b0);
        check({tag, ".drain_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [N-1:0] ro, rh;
        logic [3:0]   rf;
        logic         seen;
        exp_t         dropped;

        #2;
        check("reset.result", result, 16'h0);
        check("reset.result_hi", result_hi, 16'h0);
        check("reset.flags", flags, 4'h0);
        check("reset.out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // mul discarded by a mid-op reset
        sb.push_back(model(16'h00FF, 16'h0101, 3'd3));
        @(negedge clk);
        in_valid = 1'b1; a = 16'h00FF; b = 16'h0101; f = 3'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid.out_valid", out_valid, 1'b0);
        check("rst_mid.result", result, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("rst_add", 16'd2, 16'd3, 3'd0, 0, ro, rh, rf);
        check("rst_add.const", {rf, ro}, {4'b0000, 16'd5});

        run_op("add_wrap", 16'hFFFF, 16'h0001, 3'd0, 0, ro, rh, rf);
        check("add_wrap.const", {rf, ro}, {4'b0011, 16'h0000});
        run_op("add_ovf", 16'h7FFF, 16'h0001, 3'd0, 0, ro, rh, rf);
        check("add_ovf.const", {rf, ro}, {4'b0100, 16'h8000});

        run_op("mul", 16'h1234, 16'h5678, 3'd3, 3, ro, rh, rf);
        check("mul.const", {rh, ro}, 32'h0626_0060);

        run_op("div", 16'd1000, 16'd7, 3'd4, 0, ro, rh, rf);
        check("div.const", {rh, ro}, {16'd6, 16'd142});
        run_op("div0", 16'd5, 16'd0, 3'd4, 0, ro, rh, rf);
        check("div0.const", {rf, rh, ro}, {4'b1000, 16'd5, 16'hFFFF});

        run_op("cmp_a0", 16'd0, 16'd9, 3'd5, 0, ro, rh, rf);
        check("cmp_a0.const", ro, 16'd9);
        run_op("cmp_lt", 16'd3, 16'd9, 3'd5, 0, ro, rh, rf);
        check("cmp_lt.const", ro, 16'd3);
        run_op("cmp_gt", 16'd9, 16'd3, 3'd5, 0, ro, rh, rf);
        check("cmp_gt.const", ro, 16'd3);
        run_op("sub_neg", 16'd3, 16'd9, 3'd1, 0, ro, rh, rf);
        check("sub_neg.const", {rf[1], ro}, {1'b0, 16'hFFFA});
        run_op("mov", 16'd1, 16'h00AB, 3'd2, 0, ro, rh, rf);
        run_op("op6", 16'd1, 16'h0000, 3'd6, 0, ro, rh, rf);
        run_op("op7", 16'd1, 16'h1357, 3'd7, 0, ro, rh, rf);

        // flush in cycle 4 of a divide
        sb.push_back(model(16'd1000, 16'd7, 3'd4));
        @(negedge clk);
        in_valid = 1'b1; a = 16'd1000; b = 16'd7; f = 3'd4;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        dropped = sb.pop_front();
        check("flush.out_valid", out_valid, 1'b0);
        check("flush.in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 seen = seen | out_valid;
        end
        check("flush.never_valid", seen, 1'b0);
        run_op("post_flush_sub", 16'd6, 16'd6, 3'd1, 0, ro, rh, rf);
        check("post_flush_sub.const", {rf, ro}, {4'b0011, 16'd0});

        // flush beats a simultaneous accept
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; a = 16'd4; b = 16'd4; f = 3'd0;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        check("flush_accept.in_ready", in_ready, 1'b1);
        check("flush_accept.out_valid", out_valid, 1'b0);

        for (int i = 0; i < 10; i++) begin
            logic [N-1:0] ra, rb;
            logic [2:0]   rfn;
            ra  = N'($urandom);
            rb  = (i % 3 == 0) ? N'($urandom_range(0, 20)) : N'($urandom);
            rfn = 3'($urandom_range(0, 7));
            run_op($sformatf("rand%0d", i), ra, rb, rfn, 0, ro, rh, rf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
